// File: rtl/sdram_pro_arbit_if.sv
//------------------------------------------------------------------------------
// SdramProArbitIf
// Purpose : Bundles the SDRAM pin-side signals driven by the bus arbiter so the
//           controller top can route them to the pads as a single port.
// Signals :
//   cke                      clock enable
//   cs_n/ras_n/cas_n/we_n    command pins, {cs_n,ras_n,cas_n,we_n} = command
//   ba[1:0]                  bank address
//   addr[11:0]               row/column address
//   dq_out[15:0]             write data towards the pad
//   dq_oe                    pad output enable
// Modports:
//   master  the arbiter, drives every signal
//   slave   the pad/top side, observes every signal
//------------------------------------------------------------------------------
interface sdram_pro_arbit_if;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  ba;
    logic [11:0] addr;
    logic [15:0] dq_out;
    logic        dq_oe;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, ba, addr, dq_out, dq_oe
    );

    modport slave (
        input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, dq_out, dq_oe
    );
endinterface

// File: rtl/sdram_pro_arbit.sv
//------------------------------------------------------------------------------
// SdramProArbit (module sdram_pro_arbit)
// Purpose : Owns the single SDRAM command/address/data bus and shares it
//           between the init, auto-refresh, write and read sub-modules. The
//           init module keeps the bus until initialisation completes; after
//           that refresh has top priority and write/read alternate round-robin.
//           Grants are non-preemptive and separated by at least one NOP cycle.
// Ports   :
//   i_sys_clk / i_sys_rst          clock, synchronous active-high reset
//   i_init_end, i_init_*           init done level and init bus drive
//   i_aref_req/_end, i_aref_*      refresh request/done and bus drive
//   i_wr_req/_end, i_wr_*          write request/done and bus drive
//   i_wr_sdram_en, i_wr_sdram_data write dq enable and data
//   i_rd_req/_end, i_rd_*          read request/done and bus drive
//   o_aref_en/o_wr_en/o_rd_en      grant levels to the sub-modules
//   o_arb_err                      sticky watchdog error
//   sdram_bus                      SDRAM pin bundle (master modport)
// Options :
//   ARB_TIMEOUT_EN  when defined, a 16-bit watchdog forces a grant back to
//                   arbitration after TIMEOUT_CYC cycles without an end pulse
//                   and sets o_arb_err. When undefined, grants wait forever
//                   and o_arb_err is tied low.
//------------------------------------------------------------------------------
module sdram_pro_arbit #(
    parameter logic [3:0] CMD_NOP     = 4'b0111,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,

    input  logic        i_init_end,
    input  logic [3:0]  i_init_cmd,
    input  logic [11:0] i_init_addr,
    input  logic [1:0]  i_init_bank,

    input  logic        i_aref_req,
    input  logic        i_aref_end,
    input  logic [3:0]  i_aref_cmd,
    input  logic [11:0] i_aref_addr,
    input  logic [1:0]  i_aref_bank,

    input  logic        i_wr_req,
    input  logic        i_wr_end,
    input  logic [3:0]  i_wr_cmd,
    input  logic [11:0] i_wr_addr,
    input  logic [1:0]  i_wr_bank,
    input  logic        i_wr_sdram_en,
    input  logic [15:0] i_wr_sdram_data,

    input  logic        i_rd_req,
    input  logic        i_rd_end,
    input  logic [3:0]  i_rd_cmd,
    input  logic [11:0] i_rd_addr,
    input  logic [1:0]  i_rd_bank,

    output logic        o_aref_en,
    output logic        o_wr_en,
    output logic        o_rd_en,
    output logic        o_arb_err,

    sdram_pro_arbit_if.master sdram_bus
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ARBIT,
        ST_AREF,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t      r_state;
    logic        r_lastWr;
    logic        w_ownerEnd;
    logic        w_timeout;

    logic [3:0]  w_cmd;
    logic [1:0]  w_ba;
    logic [11:0] w_addr;
    logic [15:0] w_dqOut;
    logic        w_dqOe;

    // The end pulse only counts when it comes from the current owner; a stray
    // pulse from an idle sub-module must not release someone else's grant.
    always_comb begin
        w_ownerEnd = 1'b0;
        case (r_state)
            ST_AREF:  w_ownerEnd = i_aref_end;
            ST_WRITE: w_ownerEnd = i_wr_end;
            ST_READ:  w_ownerEnd = i_rd_end;
            default:  w_ownerEnd = 1'b0;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_wdogCnt;
    logic        r_arbErr;

    // Watchdog: cleared whenever a grant is issued, counts every owned cycle.
    // Reaching the last allowed count without an end pulse reclaims the bus.
    assign w_timeout = (r_state == ST_AREF || r_state == ST_WRITE || r_state == ST_READ)
                       && (r_wdogCnt == TO_LAST) && !w_ownerEnd;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_wdogCnt <= '0;
            r_arbErr  <= 1'b0;
        end else begin
            if (r_state == ST_ARBIT) begin
                r_wdogCnt <= '0;
            end else if (r_state != ST_INIT) begin
                r_wdogCnt <= r_wdogCnt + 16'd1;
            end
            if (w_timeout) begin
                r_arbErr <= 1'b1;
            end
        end
    end

    assign o_arb_err = r_arbErr;
`else
    assign w_timeout = 1'b0;
    assign o_arb_err = 1'b0;
`endif

    // Main arbitration FSM. Refresh beats everything; when write and read both
    // ask, r_lastWr picks whichever did not go last. Every grant returns to
    // ST_ARBIT, which guarantees one NOP cycle between owners.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state  <= ST_INIT;
            r_lastWr <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (i_init_end) begin
                        r_state <= ST_ARBIT;
                    end
                end
                ST_ARBIT: begin
                    if (i_aref_req) begin
                        r_state <= ST_AREF;
                    end else if (i_wr_req && i_rd_req) begin
                        r_state <= r_lastWr ? ST_READ : ST_WRITE;
                    end else if (i_wr_req) begin
                        r_state <= ST_WRITE;
                    end else if (i_rd_req) begin
                        r_state <= ST_READ;
                    end
                end
                ST_AREF, ST_WRITE, ST_READ: begin
                    if (w_ownerEnd || w_timeout) begin
                        r_state <= ST_ARBIT;
                        if (r_state == ST_WRITE) begin
                            r_lastWr <= 1'b1;
                        end else if (r_state == ST_READ) begin
                            r_lastWr <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Pin mux straight off the state register, so sub-module command timing
    // reaches the pads with no added latency. Reset overrides combinationally
    // so the bus goes NOP in the same cycle reset is raised.
    always_comb begin
        w_cmd   = CMD_NOP;
        w_ba    = 2'b11;
        w_addr  = 12'hfff;
        w_dqOut = 16'h0000;
        w_dqOe  = 1'b0;
        if (!i_sys_rst) begin
            case (r_state)
                ST_INIT: begin
                    w_cmd  = i_init_cmd;
                    w_ba   = i_init_bank;
                    w_addr = i_init_addr;
                end
                ST_AREF: begin
                    w_cmd  = i_aref_cmd;
                    w_ba   = i_aref_bank;
                    w_addr = i_aref_addr;
                end
                ST_WRITE: begin
                    w_cmd   = i_wr_cmd;
                    w_ba    = i_wr_bank;
                    w_addr  = i_wr_addr;
                    w_dqOut = i_wr_sdram_data;
                    w_dqOe  = i_wr_sdram_en;
                end
                ST_READ: begin
                    w_cmd  = i_rd_cmd;
                    w_ba   = i_rd_bank;
                    w_addr = i_rd_addr;
                end
                default: ;
            endcase
        end
    end

    assign o_aref_en = !i_sys_rst && (r_state == ST_AREF);
    assign o_wr_en   = !i_sys_rst && (r_state == ST_WRITE);
    assign o_rd_en   = !i_sys_rst && (r_state == ST_READ);

    assign sdram_bus.cke    = 1'b1;
    assign sdram_bus.cs_n   = w_cmd[3];
    assign sdram_bus.ras_n  = w_cmd[2];
    assign sdram_bus.cas_n  = w_cmd[1];
    assign sdram_bus.we_n   = w_cmd[0];
    assign sdram_bus.ba     = w_ba;
    assign sdram_bus.addr   = w_addr;
    assign sdram_bus.dq_out = w_dqOut;
    assign sdram_bus.dq_oe  = w_dqOe;

endmodule

// File: doc/sdram_pro_arbit.md
Name: sdram_pro_arbit

Overview:
- Owns the single SDRAM command/address/data bus and shares it between the init, auto-refresh, write and read sub-modules.
- Holds the bus with the init module until initialisation completes.
- After that, grants the bus to one requester at a time. Refresh has top priority; write and read alternate round-robin.
- Sits between the sub-module command outputs and the SDRAM pins, inside the SDRAM controller top.

Parameters:
- CMD_NOP, 4'b0111, idle command {cs_n,ras_n,cas_n,we_n} driven when no owner is active.
- TIMEOUT_CYC, 1024, watchdog limit in cycles per grant (used only with ARB_TIMEOUT_EN).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- init_end  in  1  init done, level; stays high after initialisation.
- init_cmd / init_addr / init_bank  in  4/12/2  init module bus drive.
- aref_req  in  1  refresh request, level, held until granted.
- aref_end  in  1  refresh done, 1-cycle pulse.
- aref_cmd / aref_addr / aref_bank  in  4/12/2  refresh module bus drive.
- wr_req  in  1  write request, level.
- wr_end  in  1  write done pulse.
- wr_cmd / wr_addr / wr_bank  in  4/12/2  write module bus drive.
- wr_sdram_en  in  1  write module dq drive enable.
- wr_sdram_data  in  16  write data.
- rd_req  in  1  read request, level.
- rd_end  in  1  read done pulse.
- rd_cmd / rd_addr / rd_bank  in  4/12/2  read module bus drive.
- aref_en / wr_en / rd_en  out  1  grant levels to sub-modules.
- sdram_cke  out  1  clock enable.
- sdram_cs_n / sdram_ras_n / sdram_cas_n / sdram_we_n  out  1  command pins.
- sdram_ba  out  2  bank address.
- sdram_addr  out  12  row/column address.
- sdram_dq_out  out  16  write data to the pad.
- sdram_dq_oe  out  1  pad output enable.
- arb_err  out  1  sticky watchdog error (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- States: ST_INIT, ST_ARBIT, ST_AREF, ST_WRITE, ST_READ. Encoding and state register are synchronous on sys_clk.
- Reset (sys_rst=1 at a clock edge):
  - state <= ST_INIT, last_wr <= 0, arb_err <= 0.
  - While sys_rst is high, pins are forced combinationally: cmd=CMD_NOP, ba=2'b11, addr=12'hfff, dq_oe=0, dq_out=0, cke=1, all grants=0.
- ST_INIT:
  - Mux selects init_*.
  - init_end=1 -> ST_ARBIT next cycle.
  - Requests are ignored.
- ST_ARBIT:
  - Pins = CMD_NOP / 2'b11 / 12'hfff.
  - aref_req -> ST_AREF.
  - Else if wr_req and rd_req both set -> ST_WRITE if last_wr=0, else ST_READ.
  - Else wr_req -> ST_WRITE.
  - Else rd_req -> ST_READ.
  - Else stay.
  - Decision takes effect the next cycle.
- ST_AREF / ST_WRITE / ST_READ:
  - Grant level = (state == that state), combinational from the state register.
  - Mux selects the owner's cmd/ba/addr.
  - dq_oe = wr_sdram_en and dq_out = wr_sdram_data only in ST_WRITE; otherwise dq_oe=0.
  - Owner's end pulse -> ST_ARBIT next cycle, so the grant drops on the same edge the sub-module returns to idle.
  - On leaving ST_WRITE, last_wr <= 1. On leaving ST_READ, last_wr <= 0. ST_AREF leaves last_wr unchanged.
- Non-preemptive: aref_req arriving during ST_WRITE or ST_READ waits for the owner's end pulse, then wins the next arbitration.
- Minimum spacing: at least 1 ST_ARBIT cycle (NOP on the bus) between consecutive grants.
- An end pulse from a non-owner is ignored.
- Pin outputs are a pure combinational mux of the registered state. There is no added latency, so sub-module CAS/tRCD timing is preserved.
- sdram_cke = 1 whenever sys_rst = 0.
- Reset mid-grant: the grant drops at once and the bus goes NOP. Sub-modules are reset by the same sys_rst.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With it defined:
  - A 16-bit watchdog counter clears on entry to ST_AREF, ST_WRITE or ST_READ and increments every cycle in those states.
  - Reaching TIMEOUT_CYC-1 without an end pulse forces ST_ARBIT and sets arb_err=1 (sticky until sys_rst).
  - last_wr updates as on a normal exit.
- Without it: no counter; the block waits indefinitely for the end pulse; arb_err is tied 0.

Test Plan:
- Init hold: assert rd_req before init_end, raise init_end at cycle 50 -> rd_en stays 0 until ST_ARBIT; rd_en=1 at cycle 52; pins follow init_cmd before that.
- Priority: aref_req, wr_req and rd_req all rise in the same ST_ARBIT cycle -> aref_en=1 first. After aref_end, wr_en=1 (last_wr=0). After wr_end, rd_en=1.
- Round-robin: hold wr_req and rd_req high continuously for 4 transactions -> grant order W,R,W,R, with 1 NOP cycle between each.
- Non-preemption: raise aref_req mid-write -> wr_en stays 1 until wr_end; aref_en=1 two cycles after wr_end.
- Datapath/mux: in ST_WRITE drive wr_cmd=4'b0100, wr_addr=12'h0a5, wr_sdram_data=16'h1234, wr_sdram_en=1 -> pins show 0100/0a5, dq_oe=1, dq_out=16'h1234. In ST_READ, dq_oe=0.
- Reset and timeout: assert sys_rst during ST_READ -> next edge gives cmd=0111, ba=11, addr=fff, all grants 0, state ST_INIT. With ARB_TIMEOUT_EN and TIMEOUT_CYC=16, withhold rd_end -> rd_en drops after 16 cycles and arb_err=1.
